vga_timing_gen: RTL and testbench

Pixel-timing generator for the VGA path; sits directly upstream of the background drawer and object drawers and feeds them pixelX/pixelY. Produces 640x480@60 raster counters, sync pulses and blanking. Sync and blank are delayed by a programmable number of clk cycles so they stay aligned with the registered RGB that downstream stages produce.

---
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters, sync, blank and frame markers.
//   clk          : system clock
//   resetN       : asynchronous active-low reset
//   pixelEn      : pixel-rate tick; counters and activeVideo advance only when high
//   pixelX/Y     : registered raster counters (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   activeVideo  : visible-area flag, aligned with pixelX/pixelY
//   hsyncN/vsyncN/blankN : active-low sync and blank, delayed PIPE_DELAY clk
//   startOfFrame : one-clk pulse when the counters wrap to (0,0)
//   endOfFrame   : one-clk pulse when the counters first hold (H_ACTIVE, V_ACTIVE-1)
//   frameCnt     : frame counter, steps with startOfFrame
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pixelEn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        activeVideo,
    output logic        hsyncN,
    output logic        vsyncN,
    output logic        blankN,
    output logic        startOfFrame,
    output logic        endOfFrame,
    output logic [7:0]  frameCnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] X_EOF    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_EOF    = 11'(V_ACTIVE - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        run_q, run_d, active_q, active_d, sof_q, sof_d, eof_q, eof_d;
    logic        adv, x_wrap, y_wrap, hs, vs, bl;

    // The first enabled tick after reset only arms the raster (run_q), so
    // (0,0) is presented with activeVideo=1 before the counters start moving.
    always_comb begin
        adv         = pixelEn && run_q;
        x_wrap      = pixel_x_q == H_LAST;
        y_wrap      = pixel_y_q == V_LAST;
        pixel_x_d   = adv ? (x_wrap ? 11'd0 : pixel_x_q + 11'd1) : pixel_x_q;
        pixel_y_d   = (adv && x_wrap) ? (y_wrap ? 11'd0 : pixel_y_q + 11'd1) : pixel_y_q;
        run_d       = run_q || pixelEn;
        active_d    = pixelEn ? (pixel_x_d < X_ACT && pixel_y_d < Y_ACT) : active_q;
        sof_d       = adv && x_wrap && y_wrap;
        eof_d       = adv && pixel_x_q == X_EOF && pixel_y_q == Y_EOF;
        frame_cnt_d = sof_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
        hs          = !(pixel_x_q >= HS_START && pixel_x_q < HS_END);
        vs          = !(pixel_y_q >= VS_START && pixel_y_q < VS_END);
        bl          = active_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixel_x_q   <= '0;
            pixel_y_q   <= '0;
            frame_cnt_q <= '0;
            run_q       <= 1'b0;
            active_q    <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            pixel_x_q   <= pixel_x_d;
            pixel_y_q   <= pixel_y_d;
            frame_cnt_q <= frame_cnt_d;
            run_q       <= run_d;
            active_q    <= active_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

    // Sync/blank delay line runs every clk so it tracks the downstream
    // registered RGB pipeline, independent of the pixel tick.
    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign {hsyncN, vsyncN, blankN} = {hs, vs, bl};
        end else begin : g_dly
            logic [2:0] dly_q [PIPE_DELAY];
            logic [2:0] dly_d [PIPE_DELAY];
            always_comb begin
                dly_d[0] = {hs, vs, bl};
                for (int i = 1; i < PIPE_DELAY; i++) dly_d[i] = dly_q[i-1];
            end
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= 3'b110;
                end else begin
                    for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= dly_d[i];
                end
            end
            assign {hsyncN, vsyncN, blankN} = dly_q[PIPE_DELAY-1];
        end
    endgenerate

    assign pixelX       = pixel_x_q;
    assign pixelY       = pixel_y_q;
    assign activeVideo  = active_q;
    assign startOfFrame = sof_q;
    assign endOfFrame   = eof_q;
    assign frameCnt     = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen at three delays plus a reduced raster.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic pixelEn = 1'b1;
    logic [10:0] px [4];
    logic [10:0] py [4];
    logic [7:0]  fc [4];
    logic av [4], hs_n [4], vs_n [4], bl_n [4], sof [4], eof [4];

    // instance 0: default/PIPE 1, 1: PIPE 0, 2: PIPE 3, 3: reduced 14x7 raster/PIPE 1
    int g_ha [4] = '{640, 640, 640, 8};
    int g_hf [4] = '{16, 16, 16, 2};
    int g_hw [4] = '{96, 96, 96, 2};
    int g_hb [4] = '{48, 48, 48, 2};
    int g_va [4] = '{480, 480, 480, 4};
    int g_vf [4] = '{10, 10, 10, 1};
    int g_vw [4] = '{2, 2, 2, 1};
    int g_vb [4] = '{33, 33, 33, 1};
    int g_dly [4] = '{1, 0, 3, 1};

    int checks = 0;
    int errors = 0;
    int t = 0;
    bit primed = 0;
    bit adv = 0;
    int hist_t [4] = '{0, 0, 0, 0};
    bit hist_p [4] = '{0, 0, 0, 0};
    int cnt, cnt2, cnt3;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (.clk(clk), .resetN(resetN), .pixelEn(pixelEn), .pixelX(px[0]), .pixelY(py[0]),
        .activeVideo(av[0]), .hsyncN(hs_n[0]), .vsyncN(vs_n[0]), .blankN(bl_n[0]),
        .startOfFrame(sof[0]), .endOfFrame(eof[0]), .frameCnt(fc[0]));
    vga_timing_gen #(.PIPE_DELAY(0)) u_d0 (.clk(clk), .resetN(resetN), .pixelEn(pixelEn), .pixelX(px[1]), .pixelY(py[1]),
        .activeVideo(av[1]), .hsyncN(hs_n[1]), .vsyncN(vs_n[1]), .blankN(bl_n[1]),
        .startOfFrame(sof[1]), .endOfFrame(eof[1]), .frameCnt(fc[1]));
    vga_timing_gen #(.PIPE_DELAY(3)) u_d3 (.clk(clk), .resetN(resetN), .pixelEn(pixelEn), .pixelX(px[2]), .pixelY(py[2]),
        .activeVideo(av[2]), .hsyncN(hs_n[2]), .vsyncN(vs_n[2]), .blankN(bl_n[2]),
        .startOfFrame(sof[2]), .endOfFrame(eof[2]), .frameCnt(fc[2]));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIPE_DELAY(1)) u_sm (.clk(clk), .resetN(resetN), .pixelEn(pixelEn), .pixelX(px[3]), .pixelY(py[3]),
        .activeVideo(av[3]), .hsyncN(hs_n[3]), .vsyncN(vs_n[3]), .blankN(bl_n[3]),
        .startOfFrame(sof[3]), .endOfFrame(eof[3]), .frameCnt(fc[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            if (errors <= 40) $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Expected values come from the tick count since reset: x = t mod H_TOTAL, etc.
    task automatic chk_inst(input int i);
        int ht, vt, x, y, xd, yd;
        string n;
        n  = $sformatf("u%0d", i);
        ht = g_ha[i] + g_hf[i] + g_hw[i] + g_hb[i];
        vt = g_va[i] + g_vf[i] + g_vw[i] + g_vb[i];
        x  = t % ht;
        y  = (t / ht) % vt;
        xd = hist_t[g_dly[i]] % ht;
        yd = (hist_t[g_dly[i]] / ht) % vt;
        chk({n, ".pixelX"}, px[i], x);
        chk({n, ".pixelY"}, py[i], y);
        chk({n, ".activeVideo"}, av[i], primed && x < g_ha[i] && y < g_va[i]);
        chk({n, ".frameCnt"}, fc[i], (t / (ht * vt)) % 256);
        chk({n, ".startOfFrame"}, sof[i], adv && (t % (ht * vt) == 0));
        chk({n, ".endOfFrame"}, eof[i], adv && x == g_ha[i] && y == g_va[i] - 1);
        chk({n, ".hsyncN"}, hs_n[i], !(xd >= g_ha[i] + g_hf[i] && xd < g_ha[i] + g_hf[i] + g_hw[i]));
        chk({n, ".vsyncN"}, vs_n[i], !(yd >= g_va[i] + g_vf[i] && yd < g_va[i] + g_vf[i] + g_vw[i]));
        chk({n, ".blankN"}, bl_n[i], hist_p[g_dly[i]] && xd < g_ha[i] && yd < g_va[i]);
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) chk_inst(i);
    endtask

    task automatic model_reset();
        t = 0;
        primed = 0;
        adv = 0;
        for (int k = 0; k < 4; k++) begin
            hist_t[k] = 0;
            hist_p[k] = 0;
        end
    endtask

    task automatic step(input logic en);
        pixelEn = en;
        @(posedge clk);
        #1;
        adv = 0;
        if (resetN) begin
            adv = en && primed;
            if (adv) t++;
            if (en) primed = 1;
        end
        for (int k = 3; k > 0; k--) begin
            hist_t[k] = hist_t[k-1];
            hist_p[k] = hist_p[k-1];
        end
        hist_t[0] = t;
        hist_p[0] = primed;
        check_all();
    endtask

    initial begin
        // reset held with pixelEn high
        model_reset();
        repeat (3) step(1);
        chk("rst.blankN", bl_n[0], 1'b0);
        chk("rst.frameCnt", fc[0], 8'd0);
        resetN = 1'b1;
        step(1);
        chk("release.activeVideo", av[0], 1'b1);
        chk("release.blankN_lag", bl_n[0], 1'b0);
        step(1);
        chk("release.blankN", bl_n[0], 1'b1);

        // first line: hsync width on each delay variant, then line wrap
        cnt = 0; cnt2 = 0; cnt3 = 0;
        while (t < 799) begin
            step(1);
            cnt  += int'(!hs_n[0]);
            cnt2 += int'(!hs_n[1]);
            cnt3 += int'(!hs_n[2]);
        end
        chk("line.x_last", px[0], 11'd799);
        chk("line.y_before", py[0], 11'd0);
        step(1);
        cnt += int'(!hs_n[0]);
        chk("line.x_wrap", px[0], 11'd0);
        chk("line.y_wrap", py[0], 11'd1);
        chk("line.hsync_width_d1", cnt, 96);
        chk("line.hsync_width_d0", cnt2, 96);
        chk("line.hsync_width_d3", cnt3, 96);
        while (t < 800 + 656) step(1);
        chk("d0.hsync_edge", hs_n[1], 1'b0);
        chk("d3.hsync_lag", hs_n[2], 1'b1);
        step(1); step(1);
        chk("d3.hsync_still", hs_n[2], 1'b1);
        step(1);
        chk("d3.hsync_edge", hs_n[2], 1'b0);
        while (t < 1700) step(1);

        // half-rate pixel tick
        for (int k = 0; k < 200; k++) step(k[0]);

        // reduced raster: frame markers, vsync width, stall at (0,0)
        while (t % 98 != 0) step(1);
        cnt = 0; cnt2 = 0; cnt3 = 0;
        for (int k = 0; k < 98; k++) begin
            step(1);
            cnt  += int'(!vs_n[3]);
            cnt2 += int'(eof[3]);
            cnt3 += int'(sof[3]);
        end
        chk("sm.vsync_width", cnt, 14);
        chk("sm.eof_count", cnt2, 1);
        chk("sm.sof_count", cnt3, 1);
        while ((t + 1) % 98 != 0) step(1);
        cnt = 0;
        step(1); cnt += int'(sof[3]);
        for (int k = 0; k < 3; k++) begin
            step(0);
            cnt += int'(sof[3]);
        end
        step(1); cnt += int'(sof[3]);
        chk("sm.stall_sof_count", cnt, 1);

        // frame counter wrap
        while (t < 255 * 98) step(1);
        chk("sm.frameCnt_255", fc[3], 8'd255);
        while (t < 256 * 98) step(1);
        chk("sm.frameCnt_wrap", fc[3], 8'd0);
        chk("sm.sof_at_wrap", sof[3], 1'b1);

        // asynchronous reset mid-frame at (5,2) of the reduced raster
        while (t % 98 != 33) step(1);
        chk("sm.pre_reset_x", px[3], 11'd5);
        chk("sm.pre_reset_y", py[3], 11'd2);
        resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst.frameCnt", fc[3], 8'd0);
        chk("arst.x", px[0], 11'd0);
        repeat (2) step(1);
        resetN = 1'b1;
        for (int k = 0; k < 120; k++) step(1);
        chk("arst.frameCnt_after", fc[3], 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
